// File: rtl/uart_program_loader_if.sv
// Byte-stream input, memory write port and status outputs of the program loader.
interface uart_program_loader_if;
  logic [7:0]  al_veri;
  logic        al_gecerli;
  logic [31:0] bellek_adres;
  logic [31:0] bellek_veri;
  logic        bellek_yaz;
  logic        bellek_hazir;
  logic        cekirdek_rst;
  logic        yukleme_bitti;
  logic        hata;

  // Loader side: consumes bytes, drives the memory write port and status.
  modport master (
    input  al_veri, al_gecerli, bellek_hazir,
    output bellek_adres, bellek_veri, bellek_yaz, cekirdek_rst, yukleme_bitti, hata
  );

  // Environment side: UART receiver and memory.
  modport slave (
    output al_veri, al_gecerli, bellek_hazir,
    input  bellek_adres, bellek_veri, bellek_yaz, cekirdek_rst, yukleme_bitti, hata
  );
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader: parses a framed program image from the UART byte stream, writes
// little-endian words to memory and releases the core once the checksum matches.
module uart_program_loader #(
  parameter logic [31:0] BASLANGIC_ADRESI = 32'h0000_0000,
  parameter logic [7:0]  SENKRON_BAYT     = 8'hA5,
  parameter logic [15:0] MAKS_KELIME      = 16'd4096,
  parameter logic [31:0] ZAMAN_ASIMI      = 32'd5_000_000
) (
  input logic                    clk_g,
  input logic                    rst_g,
  uart_program_loader_if.master  bus
);

  typedef enum logic [2:0] {
    StBekleSenkron, StUzunluk0, StUzunluk1, StVeri, StYaz, StSaglama, StBitti, StHata
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] adres_q, adres_d;
  logic [31:0] veri_q, veri_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] n_q, n_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_v_q, hold_v_d;

  logic        consuming;
  logic        byte_v;
  logic [7:0]  byte_b;
  logic [15:0] n_new;

  // Next-state logic: byte parsing, write handshake, holding register and timeout.
  always_comb begin
    state_d  = state_q;
    adres_d  = adres_q;
    veri_d   = veri_q;
    word_d   = word_q;
    idx_d    = idx_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    chk_d    = chk_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    n_new    = {bus.al_veri, n_q[7:0]};

    consuming = (state_q == StUzunluk0) || (state_q == StUzunluk1) ||
                (state_q == StVeri) || (state_q == StSaglama);

    // A held byte is older than any byte arriving now, so it is processed first
    // and the new one takes its place in the holding register.
    byte_v = bus.al_gecerli;
    byte_b = bus.al_veri;
    if (consuming && hold_v_q) begin
      byte_v   = 1'b1;
      byte_b   = hold_q;
      hold_v_d = bus.al_gecerli;
      hold_d   = bus.al_veri;
    end

    if (bus.al_gecerli)  tmo_d = '0;
    else if (consuming)  tmo_d = tmo_q + 32'd1;
    else                 tmo_d = '0;

    case (state_q)
      StBekleSenkron, StHata: begin
        hold_v_d = 1'b0;
        if (bus.al_gecerli && (bus.al_veri == SENKRON_BAYT)) begin
          chk_d   = '0;
          cnt_d   = '0;
          n_d     = '0;
          idx_d   = '0;
          word_d  = '0;
          adres_d = BASLANGIC_ADRESI;
          state_d = StUzunluk0;
        end
      end
      StUzunluk0: begin
        if (byte_v) begin
          n_d[7:0] = byte_b;
          chk_d    = chk_q ^ byte_b;
          state_d  = StUzunluk1;
        end
      end
      StUzunluk1: begin
        if (byte_v) begin
          n_new = {byte_b, n_q[7:0]};
          n_d   = n_new;
          chk_d = chk_q ^ byte_b;
          if (n_new > MAKS_KELIME) state_d = StHata;
          else if (n_new == 16'd0) state_d = StSaglama;
          else                     state_d = StVeri;
        end
      end
      StVeri: begin
        if (byte_v) begin
          chk_d = chk_q ^ byte_b;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            veri_d  = {byte_b, word_q};
            state_d = StYaz;
          end else begin
            word_d = {byte_b, word_q[23:8]};
          end
        end
      end
      StYaz: begin
        if (bus.al_gecerli && hold_v_q) begin
          // Second byte while stalled: no room left, abandon the frame.
          hold_v_d = 1'b0;
          state_d  = StHata;
        end else begin
          if (bus.al_gecerli) begin
            hold_d   = bus.al_veri;
            hold_v_d = 1'b1;
          end
          if (bus.bellek_hazir) begin
            adres_d = adres_q + 32'd4;
            cnt_d   = cnt_q + 16'd1;
            state_d = ((cnt_q + 16'd1) == n_q) ? StSaglama : StVeri;
          end
        end
      end
      StSaglama: begin
        if (byte_v) state_d = (byte_b == chk_q) ? StBitti : StHata;
      end
      StBitti: hold_v_d = 1'b0;
      default: state_d = StBekleSenkron;
    endcase

    if (consuming && !bus.al_gecerli && (tmo_d == ZAMAN_ASIMI)) begin
      state_d  = StHata;
      hold_v_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      state_q  <= StBekleSenkron;
      adres_q  <= BASLANGIC_ADRESI;
      veri_q   <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      chk_q    <= '0;
      tmo_q    <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adres_q  <= adres_d;
      veri_q   <= veri_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      chk_q    <= chk_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
    end
  end

  assign bus.bellek_adres  = adres_q;
  assign bus.bellek_veri   = veri_q;
  assign bus.bellek_yaz    = (state_q == StYaz);
  assign bus.cekirdek_rst  = (state_q != StBitti);
  assign bus.yukleme_bitti = (state_q == StBitti);
  assign bus.hata          = (state_q == StHata);

endmodule
